sysu_bcd_scan_display: RTL

Four-digit multiplexed seven-segment display driver that reads the BCD outputs of a cascaded chain of decade up/down counters. It snapshots the 16-bit BCD value on a strobe, applies optional leading-zero blanking, and time-multiplexes the digits onto one active-low segment bus with active-low anode selects. It sits between the counter chain and the board's common-anode display and is the read-side consumer of the counters' Q outputs.

---
 rtl/sysu_bcd_scan_display.sv | 91 +++++++++
 1 files changed

// File: rtl/sysu_bcd_scan_display.sv
// Four-digit multiplexed seven-segment driver for a BCD counter chain.
// Snapshots D on LATCH, blanks leading zeros, and scans active-low anodes/segments.
module sysu_bcd_scan_display #(
   parameter int SCAN_DIV = 4
) (
   input  logic        CP,
   input  logic        CLR,
   input  logic [15:0] D,
   input  logic        LATCH,
   input  logic        BLANK_EN,
   input  logic [3:0]  DP_SEL,
   output logic [6:0]  SEG_n,
   output logic        DP_n,
   output logic [3:0]  AN_n,
   output logic        ERR
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

   logic [15:0]   snap;
   logic [CW-1:0] cnt;
   logic [1:0]    idx;

   logic [3:0] nib;
   logic [6:0] seg_dec;
   logic [3:0] blank;
   logic       digit_blank;
   logic       d_nonbcd;

   always_comb begin
      nib = snap[{idx, 2'b00} +: 4];
      case (nib)
         4'd0:    seg_dec = 7'h40;
         4'd1:    seg_dec = 7'h79;
         4'd2:    seg_dec = 7'h24;
         4'd3:    seg_dec = 7'h30;
         4'd4:    seg_dec = 7'h19;
         4'd5:    seg_dec = 7'h12;
         4'd6:    seg_dec = 7'h02;
         4'd7:    seg_dec = 7'h78;
         4'd8:    seg_dec = 7'h00;
         4'd9:    seg_dec = 7'h10;
         default: seg_dec = 7'h3F;
      endcase
   end

   // A digit is blank only if it and every more significant nibble are zero.
   always_comb begin
      blank       = 4'b0000;
      blank[3]    = BLANK_EN && (snap[15:12] == 4'd0);
      blank[2]    = blank[3] && (snap[11:8] == 4'd0);
      blank[1]    = blank[2] && (snap[7:4] == 4'd0);
      digit_blank = blank[idx];
      d_nonbcd    = (D[3:0] > 4'd9) || (D[7:4] > 4'd9) ||
                    (D[11:8] > 4'd9) || (D[15:12] > 4'd9);
   end

   always_ff @(posedge CP) begin
      if (CLR) begin
         snap  <= 16'h0000;
         cnt   <= '0;
         idx   <= 2'd0;
         ERR   <= 1'b0;
         SEG_n <= 7'h7F;
         DP_n  <= 1'b1;
         AN_n  <= 4'b1111;
      end else begin
         if (LATCH) begin
            snap <= D;
            ERR  <= d_nonbcd;
         end
         if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (digit_blank) begin
            AN_n  <= 4'b1111;
            SEG_n <= 7'h7F;
            DP_n  <= 1'b1;
         end else begin
            AN_n  <= ~(4'b0001 << idx);
            SEG_n <= seg_dec;
            DP_n  <= ~DP_SEL[idx];
         end
      end
   end

endmodule
